interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 32 +++
 rtl/interrupt_controller.sv | 107 ++++++++++
 tb/tb_interrupt_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Core-side bundle of the interrupt controller: event sources, pc feed, eret, mask write and redirect/status outputs.
interface interrupt_controller_if;
    logic        timer_irq;
    logic        uart_irq;
    logic        core_hazard;
    logic        pc_overflow;
    logic        alu_overflow;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        eret;
    logic        cfg_we;
    logic [1:0]  cfg_wdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        in_kernel;
    logic [1:0]  pending;
    logic        double_fault;

    modport slave (
        input  timer_irq, uart_irq, core_hazard, pc_overflow, alu_overflow,
        input  pc, pc_next, eret, cfg_we, cfg_wdata,
        output redirect, redirect_pc, epc, cause, in_kernel, pending, double_fault
    );

    modport master (
        output timer_irq, uart_irq, core_hazard, pc_overflow, alu_overflow,
        output pc, pc_next, eret, cfg_we, cfg_wdata,
        input  redirect, redirect_pc, epc, cause, in_kernel, pending, double_fault
    );
endinterface

// File: rtl/interrupt_controller.sv
// RUN/KERNEL interrupt and exception controller; redirect is combinational in the event cycle, state lands on the next edge.
// No backpressure: the core must take redirect_pc whenever redirect is high.
module interrupt_controller #(
    parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
    parameter logic [31:0] EXC_VECTOR = 32'h80000008
) (
    input  logic                 clk,
    input  logic                 reset,
    interrupt_controller_if.slave bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_KERNEL = 1'b1} state_t;

    state_t      r_state;
    logic [1:0]  r_irq_q;
    logic [1:0]  r_pending;
    logic [1:0]  r_mask;
    logic [31:0] r_epc;
    logic [2:0]  r_cause;
    logic        r_double_fault;

    logic [1:0]  w_irq;
    logic [1:0]  w_irq_rise;
    logic [1:0]  w_eligible;
    logic [1:0]  w_service_clr;
    logic        w_exc;
    logic        w_take_exc;
    logic        w_take_irq;
    logic        w_take_eret;
    logic        w_redirect;
    logic [2:0]  w_exc_cause;
    logic [31:0] w_redirect_pc;

    assign w_irq      = {bus.uart_irq, bus.timer_irq};
    assign w_irq_rise = w_irq & ~r_irq_q;
    assign w_eligible = r_pending & r_mask;
    assign w_exc      = bus.core_hazard | bus.pc_overflow | bus.alu_overflow;

    assign w_take_exc  = (r_state == ST_RUN) && w_exc;
    assign w_take_irq  = (r_state == ST_RUN) && !w_exc && (|w_eligible);
    assign w_take_eret = (r_state == ST_KERNEL) && bus.eret;
    // Gated by reset so nothing escapes while an abandoned handler is being torn down.
    assign w_redirect  = !reset && (w_take_exc || w_take_irq || w_take_eret);

    always_comb begin
        w_exc_cause = 3'd0;
        if (bus.core_hazard)       w_exc_cause = 3'd1;
        else if (bus.pc_overflow)  w_exc_cause = 3'd2;
        else if (bus.alu_overflow) w_exc_cause = 3'd3;
    end

    always_comb begin
        w_service_clr = 2'b00;
        if (w_take_irq) w_service_clr = w_eligible[0] ? 2'b01 : 2'b10;
    end

    always_comb begin
        w_redirect_pc = bus.pc_next;
        if (w_redirect) begin
            if (w_take_exc)      w_redirect_pc = EXC_VECTOR;
            else if (w_take_irq) w_redirect_pc = IRQ_VECTOR;
            else                 w_redirect_pc = r_epc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_irq_q        <= 2'b00;
            r_pending      <= 2'b00;
            r_mask         <= 2'b11;
            r_epc          <= 32'd0;
            r_cause        <= 3'd0;
            r_double_fault <= 1'b0;
        end else begin
            r_irq_q   <= w_irq;
            // A fresh edge on the serviced source re-arms it in the same cycle.
            r_pending <= (r_pending & ~w_service_clr) | w_irq_rise;
            if (bus.cfg_we) r_mask <= bus.cfg_wdata;
            case (r_state)
                ST_RUN: begin
                    if (w_take_exc) begin
                        r_epc   <= bus.pc;
                        r_cause <= w_exc_cause;
                        r_state <= ST_KERNEL;
                    end else if (w_take_irq) begin
                        r_epc   <= bus.pc_next;
                        r_cause <= w_service_clr[0] ? 3'd4 : 3'd5;
                        r_state <= ST_KERNEL;
                    end
                end
                ST_KERNEL: begin
                    if (w_exc)    r_double_fault <= 1'b1;
                    if (bus.eret) r_state        <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.redirect     = w_redirect;
    assign bus.redirect_pc  = w_redirect_pc;
    assign bus.epc          = r_epc;
    assign bus.cause        = r_cause;
    assign bus.in_kernel    = (r_state == ST_KERNEL);
    assign bus.pending      = r_pending;
    assign bus.double_fault = r_double_fault;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed stimulus pushes expected redirects and status snapshots; a negedge monitor pops and compares them.
module tb_interrupt_controller;
    localparam logic [31:0] IRQV = 32'h80000004;
    localparam logic [31:0] EXCV = 32'h80000008;

    typedef struct {
        int          cyc;
        logic [31:0] rpc;
    } redir_t;

    typedef struct {
        string       name;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [2:0]  cause;
        logic [1:0]  pend;
        logic        kern;
        logic        df;
    } snap_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    redir_t q_redir[$];
    snap_t  q_snap[$];

    logic [31:0] e_epc;
    logic [2:0]  e_cause;
    logic [1:0]  e_pend;
    logic        e_kern;
    logic        e_df;

    logic [2:0] pats[4]  = '{3'b111, 3'b011, 3'b100, 3'b010};
    logic [2:0] codes[4] = '{3'd1, 3'd2, 3'd1, 3'd2};

    interrupt_controller_if bus ();

    interrupt_controller #(.IRQ_VECTOR(IRQV), .EXC_VECTOR(EXCV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_redir(input logic [31:0] rpc);
        redir_t r;
        r.cyc = cyc;
        r.rpc = rpc;
        q_redir.push_back(r);
    endtask

    task automatic snap(input string nm, input logic [31:0] rpc);
        snap_t s;
        s.name  = nm;
        s.rpc   = rpc;
        s.epc   = e_epc;
        s.cause = e_cause;
        s.pend  = e_pend;
        s.kern  = e_kern;
        s.df    = e_df;
        q_snap.push_back(s);
    endtask

    // Monitor: decoupled from stimulus, runs every negedge.
    always @(negedge clk) begin
        redir_t r;
        snap_t  s;
        while (q_redir.size() > 0 && q_redir[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL redirect_missing: got none expected redirect_pc %h in cycle %0d", q_redir[0].rpc, q_redir[0].cyc);
            void'(q_redir.pop_front());
        end
        if (q_redir.size() > 0 && q_redir[0].cyc == cyc) begin
            r = q_redir.pop_front();
            chk("event", "redirect", 32'(bus.redirect), 32'd1);
            chk("event", "redirect_pc", bus.redirect_pc, r.rpc);
        end else begin
            chk("idle", "redirect", 32'(bus.redirect), 32'd0);
        end
        while (q_snap.size() > 0) begin
            s = q_snap.pop_front();
            chk(s.name, "redirect_pc", bus.redirect_pc, s.rpc);
            chk(s.name, "epc", bus.epc, s.epc);
            chk(s.name, "cause", 32'(bus.cause), 32'(s.cause));
            chk(s.name, "pending", 32'(bus.pending), 32'(s.pend));
            chk(s.name, "in_kernel", 32'(bus.in_kernel), 32'(s.kern));
            chk(s.name, "double_fault", 32'(bus.double_fault), 32'(s.df));
        end
    end

    initial begin
        logic [31:0] a;
        bus.timer_irq = 0; bus.uart_irq = 0;
        bus.core_hazard = 0; bus.pc_overflow = 0; bus.alu_overflow = 0;
        bus.pc = 32'hFC; bus.pc_next = 32'h100; bus.eret = 0;
        bus.cfg_we = 0; bus.cfg_wdata = 2'b00;
        e_epc = 0; e_cause = 0; e_pend = 0; e_kern = 0; e_df = 0;

        step(); snap("reset_hold", 32'h100);
        step(); reset = 0;

        // Timer interrupt from RUN
        bus.pc = 32'h3C; bus.pc_next = 32'h40; bus.timer_irq = 1; snap("tmr_rise", 32'h40);
        step(); e_pend = 2'b01; expect_redir(IRQV); snap("tmr_redir", IRQV);
        step(); bus.timer_irq = 0; bus.pc = 32'h80000004; bus.pc_next = 32'h80000008;
        e_epc = 32'h40; e_cause = 3'd4; e_pend = 2'b00; e_kern = 1; snap("tmr_kernel", 32'h80000008);
        step(); bus.eret = 1; bus.pc_next = 32'h8000000C; expect_redir(32'h40); snap("tmr_eret", 32'h40);
        step(); bus.eret = 0; bus.pc = 32'h40; bus.pc_next = 32'h44; e_kern = 0; snap("tmr_run", 32'h44);
        step(); bus.eret = 1; bus.pc = 32'h44; bus.pc_next = 32'h48; snap("eret_in_run", 32'h48);

        // ALU overflow beats a pending UART
        step(); bus.eret = 0; bus.uart_irq = 1; bus.pc = 32'h48; bus.pc_next = 32'h4C; snap("uart_rise", 32'h4C);
        step(); bus.alu_overflow = 1; bus.pc = 32'h20; bus.pc_next = 32'h24; e_pend = 2'b10;
        expect_redir(EXCV); snap("alu_redir", EXCV);
        step(); bus.alu_overflow = 0; bus.uart_irq = 0; bus.pc = 32'h80000008; bus.pc_next = 32'h8000000C;
        e_epc = 32'h20; e_cause = 3'd3; e_kern = 1; snap("alu_kernel", 32'h8000000C);
        step(); bus.eret = 1; bus.pc_next = 32'h80000010; expect_redir(32'h20); snap("alu_eret", 32'h20);
        step(); bus.eret = 0; bus.pc = 32'h20; bus.pc_next = 32'h24; e_kern = 0;
        expect_redir(IRQV); snap("uart_after_ret", IRQV);
        step(); bus.pc = 32'h80000004; bus.pc_next = 32'h80000008;
        e_epc = 32'h24; e_cause = 3'd5; e_pend = 2'b00; e_kern = 1; snap("uart_kernel", 32'h80000008);
        step(); bus.eret = 1; expect_redir(32'h24); snap("uart_eret", 32'h24);
        step(); bus.eret = 0; bus.pc = 32'h24; bus.pc_next = 32'h28; e_kern = 0; snap("uart_run", 32'h28);

        // UART edge deferred while in KERNEL
        step(); bus.pc = 32'h40; bus.pc_next = 32'h44; bus.timer_irq = 1; snap("def_rise", 32'h44);
        step(); e_pend = 2'b01; expect_redir(IRQV); snap("def_tmr", IRQV);
        step(); bus.timer_irq = 0; bus.uart_irq = 1; bus.pc = 32'h80000004; bus.pc_next = 32'h80000008;
        e_epc = 32'h44; e_cause = 3'd4; e_pend = 2'b00; e_kern = 1; snap("def_kernel", 32'h80000008);
        step(); bus.uart_irq = 0; bus.pc_next = 32'h8000000C; e_pend = 2'b10; snap("def_held", 32'h8000000C);
        step(); bus.eret = 1; expect_redir(32'h44); snap("def_eret", 32'h44);
        step(); bus.eret = 0; bus.pc = 32'h44; bus.pc_next = 32'h48; e_kern = 0;
        expect_redir(IRQV); snap("def_uart", IRQV);
        step(); bus.pc = 32'h80000004; bus.pc_next = 32'h80000008;
        e_epc = 32'h48; e_cause = 3'd5; e_pend = 2'b00; e_kern = 1; snap("def_uart_kernel", 32'h80000008);
        step(); bus.eret = 1; expect_redir(32'h48); snap("def_uart_eret", 32'h48);
        step(); bus.eret = 0; bus.pc = 32'h48; bus.pc_next = 32'h4C; e_kern = 0; snap("def_run", 32'h4C);

        // Masking, then unmask; timer edge coinciding with its own service
        step(); bus.cfg_we = 1; bus.cfg_wdata = 2'b10; snap("mask_wr", 32'h4C);
        step(); bus.cfg_we = 0; bus.timer_irq = 1; snap("mask_rise", 32'h4C);
        step(); bus.timer_irq = 0; e_pend = 2'b01; snap("masked", 32'h4C);
        step(); bus.cfg_we = 1; bus.cfg_wdata = 2'b11; snap("unmask_wr", 32'h4C);
        step(); bus.cfg_we = 0; bus.timer_irq = 1; bus.pc = 32'h4C; bus.pc_next = 32'h50;
        expect_redir(IRQV); snap("unmasked", IRQV);
        step(); bus.timer_irq = 0; bus.pc = 32'h80000004; bus.pc_next = 32'h80000008;
        e_epc = 32'h50; e_cause = 3'd4; e_pend = 2'b01; e_kern = 1; snap("edge_wins", 32'h80000008);
        step(); bus.eret = 1; expect_redir(32'h50); snap("edge_eret", 32'h50);
        step(); bus.eret = 0; bus.pc = 32'h50; bus.pc_next = 32'h54; e_kern = 0;
        expect_redir(IRQV); snap("rearmed_tmr", IRQV);
        step(); bus.pc = 32'h80000004; bus.pc_next = 32'h80000008;
        e_epc = 32'h54; e_cause = 3'd4; e_pend = 2'b00; e_kern = 1; snap("rearmed_kernel", 32'h80000008);

        // Exception while in KERNEL
        step(); bus.pc_overflow = 1; snap("df_cycle", 32'h80000008);
        step(); bus.pc_overflow = 0; e_df = 1; snap("df_set", 32'h80000008);
        step(); bus.eret = 1; expect_redir(32'h54); snap("df_eret", 32'h54);
        step(); bus.eret = 0; bus.pc = 32'h54; bus.pc_next = 32'h58; e_kern = 0; snap("df_sticky", 32'h58);

        // Exception priority
        for (int i = 0; i < 4; i++) begin
            a = 32'h200 + 32'(i) * 32'd16;
            step(); {bus.core_hazard, bus.pc_overflow, bus.alu_overflow} = pats[i];
            bus.pc = a; bus.pc_next = a + 32'd4; expect_redir(EXCV); snap("prio_redir", EXCV);
            step(); {bus.core_hazard, bus.pc_overflow, bus.alu_overflow} = 3'b000;
            bus.pc = 32'h80000008; bus.pc_next = 32'h8000000C;
            e_epc = a; e_cause = codes[i]; e_kern = 1; snap("prio_kernel", 32'h8000000C);
            step(); bus.eret = 1; expect_redir(a); snap("prio_eret", a);
            step(); bus.eret = 0; bus.pc = a; bus.pc_next = a + 32'd4; e_kern = 0; snap("prio_run", a + 32'd4);
        end

        // Reset mid-handler with both requests pending
        step(); bus.alu_overflow = 1; bus.pc = 32'h300; bus.pc_next = 32'h304; expect_redir(EXCV); snap("rst_enter", EXCV);
        step(); bus.alu_overflow = 0; bus.timer_irq = 1; bus.uart_irq = 1;
        bus.pc = 32'h80000008; bus.pc_next = 32'h8000000C;
        e_epc = 32'h300; e_cause = 3'd3; e_kern = 1; snap("rst_kernel", 32'h8000000C);
        step(); e_pend = 2'b11; snap("rst_pend", 32'h8000000C);
        step(); reset = 1; bus.eret = 1; bus.pc_overflow = 1;
        e_epc = 0; e_cause = 0; e_pend = 0; e_kern = 0; e_df = 0; snap("rst_async", 32'h8000000C);
        step(); bus.timer_irq = 0; bus.uart_irq = 0; bus.eret = 0; snap("rst_hold", 32'h8000000C);
        step(); bus.pc_overflow = 0; reset = 0; bus.pc = 32'h400; bus.pc_next = 32'h404; snap("rst_release", 32'h404);
        step(); snap("rst_quiet", 32'h404);

        step(); step();
        n_checks++;
        if (q_redir.size() != 0) begin
            n_fail++;
            $display("FAIL redirect_leftover: got %0d unseen expected 0", q_redir.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
